// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizes for the data-memory arbiter.
package dmem_arb_pkg;

   localparam int ADDR_W_DEF  = 8;
   localparam int DATA_W_DEF  = 16;
   localparam int MEM_LAT_DEF = 1;

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_e;
   typedef enum logic       {CPU = 1'b0, DMA = 1'b1}    owner_e;

endpackage

// File: rtl/dmem_arb_if.sv
// Signal bundle between the arbiter, its CPU and DMA requesters and the data memory.
interface dmem_arb_if
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) ();

   logic              cpu_req;
   logic              cpu_wr;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_gnt;
   logic              cpu_done;
   logic [DATA_W-1:0] cpu_rdata;

   logic              dma_req;
   logic              dma_wr;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic              dma_gnt;
   logic              dma_done;
   logic [DATA_W-1:0] dma_rdata;

   logic [ADDR_W-1:0] D_addr;
   logic              D_wr;
   logic [DATA_W-1:0] D_wdata;
   logic [DATA_W-1:0] D_rdata;

   logic              busy;
   logic              owner;

   modport slave (
      input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
      input  dma_req, dma_wr, dma_addr, dma_wdata,
      input  D_rdata,
      output cpu_gnt, cpu_done, cpu_rdata,
      output dma_gnt, dma_done, dma_rdata,
      output D_addr, D_wr, D_wdata,
      output busy, owner
   );

   modport master (
      output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
      output dma_req, dma_wr, dma_addr, dma_wdata,
      output D_rdata,
      input  cpu_gnt, cpu_done, cpu_rdata,
      input  dma_gnt, dma_done, dma_rdata,
      input  D_addr, D_wr, D_wdata,
      input  busy, owner
   );

endinterface

// File: rtl/dmem_arb_sel.sv
// Winner selection between CPU and DMA: a lone requester wins, a tie goes to
// whichever requester was not served last.
module dmem_arb_sel
   import dmem_arb_pkg::*;
(
   input  logic   cpu_req,
   input  logic   dma_req,
   input  owner_e last_served,
   output owner_e winner
);

   always_comb begin
      winner = CPU;
      if (cpu_req && dma_req) begin
         winner = (last_served == CPU) ? DMA : CPU;
      end else if (dma_req) begin
         winner = DMA;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter (CPU, DMA) sequencing one access at a time.
// Define DMEM_ARB_RR_EN for round-robin tie breaking; otherwise the CPU wins ties.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int MEM_LAT = MEM_LAT_DEF
) (
   input  logic       Clock,
   input  logic       ResetN,
   dmem_arb_if.slave  bus
);

   localparam logic [1:0] LAST_WAIT = 2'(MEM_LAT - 1);

   state_e            state_q, state_d;
   owner_e            owner_q;
   owner_e            winner;
   owner_e            last_served;
   logic              cap_wr_q;
   logic [ADDR_W-1:0] cap_addr_q;
   logic [DATA_W-1:0] cap_wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic [1:0]        wait_cnt_q;
   logic              any_req;
   logic              leave_idle;

   assign any_req    = bus.cpu_req | bus.dma_req;
   assign leave_idle = (state_q == IDLE) && any_req;

`ifdef DMEM_ARB_RR_EN
   owner_e last_q;

   // Starts at DMA so the first tie after reset goes to the CPU.
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         last_q <= DMA;
      end else if (leave_idle) begin
         last_q <= winner;
      end
   end

   assign last_served = last_q;
`else
   // A constant DMA pointer makes the selector favour the CPU on every tie.
   assign last_served = DMA;
`endif

   dmem_arb_sel u_sel (
      .cpu_req     (bus.cpu_req),
      .dma_req     (bus.dma_req),
      .last_served (last_served),
      .winner      (winner)
   );

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state_q     <= IDLE;
         owner_q     <= CPU;
         cap_wr_q    <= 1'b0;
         cap_addr_q  <= '0;
         cap_wdata_q <= '0;
         rdata_q     <= '0;
         wait_cnt_q  <= '0;
      end else begin
         state_q <= state_d;
         if (leave_idle) begin
            owner_q <= winner;
            if (winner == DMA) begin
               cap_wr_q    <= bus.dma_wr;
               cap_addr_q  <= bus.dma_addr;
               cap_wdata_q <= bus.dma_wdata;
            end else begin
               cap_wr_q    <= bus.cpu_wr;
               cap_addr_q  <= bus.cpu_addr;
               cap_wdata_q <= bus.cpu_wdata;
            end
         end
         if (state_q == ACCESS) begin
            wait_cnt_q <= '0;
         end else if (state_q == WAIT) begin
            wait_cnt_q <= wait_cnt_q + 2'd1;
         end
         if (state_q == WAIT && wait_cnt_q == LAST_WAIT) begin
            rdata_q <= bus.D_rdata;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      bus.cpu_gnt   = 1'b0;
      bus.cpu_done  = 1'b0;
      bus.cpu_rdata = '0;
      bus.dma_gnt   = 1'b0;
      bus.dma_done  = 1'b0;
      bus.dma_rdata = '0;
      bus.D_addr    = '0;
      bus.D_wr      = 1'b0;
      bus.D_wdata   = '0;
      case (state_q)
         IDLE: begin
            if (any_req) state_d = ACCESS;
         end
         ACCESS: begin
            state_d     = cap_wr_q ? DONE : WAIT;
            bus.cpu_gnt = (owner_q == CPU);
            bus.dma_gnt = (owner_q == DMA);
            bus.D_addr  = cap_addr_q;
            bus.D_wr    = cap_wr_q;
            bus.D_wdata = cap_wdata_q;
         end
         WAIT: begin
            if (wait_cnt_q == LAST_WAIT) state_d = DONE;
            bus.D_addr = cap_addr_q;
         end
         DONE: begin
            state_d      = IDLE;
            bus.cpu_done = (owner_q == CPU);
            bus.dma_done = (owner_q == DMA);
            // Read data only travels back on the owner's port, and only for reads.
            if (!cap_wr_q) begin
               if (owner_q == DMA) bus.dma_rdata = rdata_q;
               else                bus.cpu_rdata = rdata_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.busy  = (state_q != IDLE);
   assign bus.owner = owner_q;

endmodule
